// File: rtl/transition_player_pkg.sv
// Shared definitions for the transition player: event word layout, FIFO depth
// and playback state encoding.
package transition_player_pkg;

  localparam int FIFO_DEPTH  = 8;
  localparam int EV_W        = 64;
  localparam int EV_LEVEL    = 0;
  localparam int EV_TIME_LSB = 1;
  localparam int EV_TIME_MSB = 63;

  typedef enum logic [1:0] {
    TP_IDLE = 2'd0,
    TP_WAIT = 2'd1,
    TP_GAP  = 2'd2
  } tp_state_e;

  function automatic logic [EV_TIME_MSB-EV_TIME_LSB:0] ev_time(input logic [EV_W-1:0] w);
    return w[EV_TIME_MSB:EV_TIME_LSB];
  endfunction

endpackage

// File: rtl/ptrfifo.sv
// Pointer-based synchronous FIFO with an extra wrap bit to tell full from empty.
module ptrfifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic             do_push, do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + 1'b1;
      if (do_pop)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/transition_player_byte_stager.sv
// 8-to-64 byte-lane staging register; host assembles an event word one byte at a time.
module byte_stager (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wrbyte,
  input  logic [2:0]  byteaddr,
  input  logic [7:0]  datain,
  output logic [63:0] word
);

  logic [63:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (wrbyte) word_d[{byteaddr, 3'b000} +: 8] = datain;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) word_q <= '0;
    else       word_q <= word_d;
  end

  assign word = word_q;

endmodule

// File: rtl/transition_player.sv
// Replays timestamped level changes ({time, level} words) onto one pin when the
// shared free-running counter reaches each event's timestamp.
module transition_player
  import transition_player_pkg::*;
#(
  parameter int   DEPTH      = FIFO_DEPTH,
  parameter logic INIT_LEVEL = 1'b0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [62:0] counterin,
  input  logic [2:0]  byteaddr,
  input  logic [7:0]  datain,
  input  logic        wrbyte,
  input  logic        commit,
  input  logic        run,
  input  logic        flush,
  input  logic        clearerr,
  output logic        dataout,
  output logic        full,
  output logic        overrun,
  output logic        late,
  output logic        attention
);

  logic [EV_W-1:0] staging, head;
  logic [62:0]     head_time;
  logic            empty, fifo_full, push, pop, fire_late, overrun_set;

  tp_state_e state_q, state_d;
  logic      dataout_q, dataout_d;
  logic      overrun_q, overrun_d;
  logic      late_q, late_d;
  logic      attention_q, attention_d;

  byte_stager u_stager (
    .clk      (clk),
    .rstn     (rstn),
    .wrbyte   (wrbyte),
    .byteaddr (byteaddr),
    .datain   (datain),
    .word     (staging)
  );

  // Commit sees the registered staging word, so a same-cycle byte write lands after the push.
  assign push        = commit && !fifo_full && !flush;
  assign overrun_set = commit && fifo_full && !flush;

  ptrfifo #(.WIDTH(EV_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .push  (push),
    .wdata (staging),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (empty)
  );

  assign head_time = ev_time(head);

  always_comb begin
    state_d   = state_q;
    dataout_d = dataout_q;
    pop       = 1'b0;
    fire_late = 1'b0;
    unique case (state_q)
      TP_IDLE: if (run && !empty) state_d = TP_WAIT;
      TP_WAIT: begin
        if (!run) begin
          state_d = TP_IDLE;
        end else if (head_time <= counterin) begin
          pop       = 1'b1;
          dataout_d = head[EV_LEVEL];
          fire_late = (head_time < counterin);
          state_d   = TP_GAP;
        end
      end
      // The popped head needs one clock before the next entry is visible.
      TP_GAP:  state_d = (run && !empty) ? TP_WAIT : TP_IDLE;
      default: state_d = TP_IDLE;
    endcase
    if (flush) begin
      state_d   = TP_IDLE;
      dataout_d = INIT_LEVEL;
      pop       = 1'b0;
      fire_late = 1'b0;
    end
  end

  always_comb begin
    overrun_d   = overrun_set || (overrun_q && !clearerr);
    late_d      = fire_late || (late_q && !clearerr);
    attention_d = (empty && run) || overrun_q || late_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= TP_IDLE;
      dataout_q   <= INIT_LEVEL;
      overrun_q   <= 1'b0;
      late_q      <= 1'b0;
      attention_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dataout_q   <= dataout_d;
      overrun_q   <= overrun_d;
      late_q      <= late_d;
      attention_q <= attention_d;
    end
  end

  assign dataout   = dataout_q;
  assign full      = fifo_full;
  assign overrun   = overrun_q;
  assign late      = late_q;
  assign attention = attention_q;

endmodule

// File: tb/tb_transition_player.sv
// Directed, table-driven bench for transition_player: replay timing, late/overrun
// flags, attention, staging order and flush behaviour.
module tb_transition_player;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [62:0] counterin = '0;
  logic [2:0]  byteaddr = '0;
  logic [7:0]  datain = '0;
  logic        wrbyte = 1'b0, commit = 1'b0, run = 1'b0, flush = 1'b0, clearerr = 1'b0;
  logic        dataout, full, overrun, late, attention;

  transition_player #(.DEPTH(DEPTH), .INIT_LEVEL(1'b0)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .counterin (counterin),
    .byteaddr  (byteaddr),
    .datain    (datain),
    .wrbyte    (wrbyte),
    .commit    (commit),
    .run       (run),
    .flush     (flush),
    .clearerr  (clearerr),
    .dataout   (dataout),
    .full      (full),
    .overrun   (overrun),
    .late      (late),
    .attention (attention)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [62:0] t;
    logic        lvl;
    logic [62:0] fire;
    logic        late;
  } ev_t;

  ev_t  tab [16];
  int   n_cmp = 0;
  int   n_fail = 0;
  logic cnt_run = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t, counterin=%0d)", name, act, exp, $time, counterin);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (cnt_run) counterin = counterin + 63'd1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    {wrbyte, commit, run, flush, clearerr, cnt_run} = '0;
    #2;
    @(negedge clk);
    rstn = 1'b1;
    tick();
  endtask

  task automatic stage_word(input logic [63:0] w);
    for (int b = 0; b < 8; b++) begin
      byteaddr = b[2:0];
      datain   = w[8*b +: 8];
      wrbyte   = 1'b1;
      tick();
    end
    wrbyte = 1'b0;
  endtask

  task automatic load_word(input logic [63:0] w);
    stage_word(w);
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic replay(input int n, input logic [62:0] c0, input logic [62:0] c1,
                        input logic d0, input logic ov);
    int          idx;
    logic        ed, el, att;
    logic [62:0] c;
    idx = 0; ed = d0; el = 1'b0;
    counterin = c0; run = 1'b1; cnt_run = 1'b1;
    while (counterin <= c1) begin
      c   = counterin;
      att = (idx == n) || el || ov;
      tick();
      if (idx < n && c == tab[idx].fire) begin
        ed  = tab[idx].lvl;
        el  = el | tab[idx].late;
        idx++;
      end
      chk("replay_dataout", {63'd0, dataout}, {63'd0, ed});
      chk("replay_late", {63'd0, late}, {63'd0, el});
      chk("replay_attention", {63'd0, attention}, {63'd0, att});
    end
    chk("replay_events_fired", idx, n);
    cnt_run = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] w;

    // Reset values while reset is asserted
    rstn = 1'b0;
    #2;
    chk("rst_dataout", {63'd0, dataout}, 64'd0);
    chk("rst_full", {63'd0, full}, 64'd0);
    chk("rst_overrun", {63'd0, overrun}, 64'd0);
    chk("rst_late", {63'd0, late}, 64'd0);
    chk("rst_attention", {63'd0, attention}, 64'd0);

    // Single on-time event at T=100, level 1
    do_reset();
    load_word({63'd100, 1'b1});
    tab[0] = '{t: 63'd100, lvl: 1'b1, fire: 63'd100, late: 1'b0};
    replay(1, 63'd0, 63'd110, 1'b0, 1'b0);

    // 200 and 300 on time; 201 too close, fires at 202 and flags late
    do_reset();
    tab[0] = '{t: 63'd200, lvl: 1'b1, fire: 63'd200, late: 1'b0};
    tab[1] = '{t: 63'd201, lvl: 1'b0, fire: 63'd202, late: 1'b1};
    tab[2] = '{t: 63'd300, lvl: 1'b1, fire: 63'd300, late: 1'b0};
    for (int i = 0; i < 3; i++) load_word({tab[i].t, tab[i].lvl});
    replay(3, 63'd190, 63'd310, 1'b0, 1'b0);
    clearerr = 1'b1; tick(); clearerr = 1'b0;
    chk("clearerr_late", {63'd0, late}, 64'd0);

    // DEPTH+1 commits with run low: last word dropped, overrun set
    do_reset();
    for (int i = 0; i <= DEPTH; i++) begin
      w = {63'd1000 + 63'(10 * i), ~i[0]};
      if (i < DEPTH) tab[i] = '{t: w[63:1], lvl: w[0], fire: w[63:1], late: 1'b0};
      load_word(w);
      if (i == DEPTH - 2) chk("full_before_last", {63'd0, full}, 64'd0);
      if (i == DEPTH - 1) begin
        chk("full_at_depth", {63'd0, full}, 64'd1);
        chk("no_overrun_at_depth", {63'd0, overrun}, 64'd0);
      end
      if (i == DEPTH) chk("overrun_after_extra", {63'd0, overrun}, 64'd1);
    end
    replay(DEPTH, 63'd990, 63'd1090, 1'b0, 1'b1);
    clearerr = 1'b1; tick(); clearerr = 1'b0;
    chk("clearerr_overrun", {63'd0, overrun}, 64'd0);

    // Event already in the past when committed
    do_reset();
    counterin = 63'd80;
    load_word({63'd50, 1'b1});
    run = 1'b1;
    tick();
    chk("past_ev_cycle1", {63'd0, dataout}, 64'd0);
    tick();
    chk("past_ev_cycle2", {63'd0, dataout}, 64'd1);
    chk("past_ev_late", {63'd0, late}, 64'd1);

    // run dropped while waiting on T=500, re-raised at counter 600
    do_reset();
    load_word({63'd500, 1'b1});
    counterin = 63'd400; run = 1'b1; cnt_run = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    run = 1'b0;
    tick();
    cnt_run = 1'b0;
    counterin = 63'd550;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("run_low_hold", {63'd0, dataout}, 64'd0);
    end
    counterin = 63'd600; run = 1'b1;
    tick();
    chk("rerun_cycle1", {63'd0, dataout}, 64'd0);
    tick();
    chk("rerun_fire", {63'd0, dataout}, 64'd1);
    chk("rerun_late", {63'd0, late}, 64'd1);

    // flush mid-playback with a same-cycle commit
    do_reset();
    load_word({63'd2000, 1'b1});
    load_word({63'd2010, 1'b0});
    load_word({63'd2020, 1'b1});
    counterin = 63'd1990; run = 1'b1; cnt_run = 1'b1;
    while (counterin < 63'd2003) tick();
    chk("pre_flush_dataout", {63'd0, dataout}, 64'd1);
    flush = 1'b1; commit = 1'b1;
    tick();
    flush = 1'b0; commit = 1'b0;
    chk("flush_dataout", {63'd0, dataout}, 64'd0);
    chk("flush_overrun", {63'd0, overrun}, 64'd0);
    while (counterin < 63'd2030) begin
      tick();
      chk("post_flush_quiet", {63'd0, dataout}, 64'd0);
    end
    chk("post_flush_attention", {63'd0, attention}, 64'd1);
    cnt_run = 1'b0; run = 1'b0;

    // flush while full with a concurrent commit must not raise overrun
    do_reset();
    for (int i = 0; i < DEPTH; i++) load_word({63'd5000 + 63'(i), 1'b1});
    chk("fill_full", {63'd0, full}, 64'd1);
    flush = 1'b1; commit = 1'b1;
    tick();
    flush = 1'b0; commit = 1'b0;
    chk("flush_full_cleared", {63'd0, full}, 64'd0);
    chk("flush_full_no_overrun", {63'd0, overrun}, 64'd0);

    // byte write and commit together: the FIFO takes the pre-write word
    do_reset();
    stage_word({63'd10, 1'b1});
    byteaddr = 3'd0; datain = 8'h14; wrbyte = 1'b1; commit = 1'b1;
    tick();
    wrbyte = 1'b0; commit = 1'b0;
    tab[0] = '{t: 63'd10, lvl: 1'b1, fire: 63'd10, late: 1'b0};
    replay(1, 63'd0, 63'd15, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
